// File: rtl/sw_adaptor_arbiter.sv
// Round-robin arbiter that shares one software adaptor channel among NREQ requesters.
// Optional response timeout is enabled by defining SWA_ARB_TIMEOUT_EN.
module sw_adaptor_arbiter #(
    parameter int NREQ      = 4,
    parameter int PKT_S     = 32,
    parameter int D_S       = 128,
    parameter int KH_S      = 64,
    parameter int DT_S      = 3,
    parameter int TO_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid_i,
    output logic [NREQ-1:0]        req_ready_o,
    input  logic [NREQ*DT_S-1:0]   req_type_i,
    input  logic [NREQ*KH_S-1:0]   req_key_i,
    output logic [NREQ-1:0]        rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [D_S-1:0]         rsp_data_o,
    output logic                   rsp_err_o,
    output logic [PKT_S-1:0]       adp_data_in,
    output logic                   adp_req_valid,
    output logic                   adp_rd_ready,
    input  logic [PKT_S-1:0]       adp_data_out,
    input  logic                   adp_rsp_valid
);

    localparam int IW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || D_S != 4 * PKT_S || KH_S != 2 * PKT_S ||
        DT_S > PKT_S || TO_CYCLES < 1) begin : g_bad_cfg
        $error("sw_adaptor_arbiter: illegal parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2,
        S_DLV  = 2'd3
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [IW-1:0]     ptr_r, gnt_r, gnt_idx_s, ptr_nxt_s;
    logic [IW:0]       cand_s, ptr_inc_s;
    logic              gnt_found_s;
    logic [DT_S-1:0]   type_r;
    logic [KH_S-1:0]   key_r;
    logic [1:0]        beat_r, word_r;
    logic [D_S-1:0]    data_r;
    logic              to_hit_s;
    logic [NREQ-1:0]   req_ready_s, rsp_valid_s;
    logic [PKT_S-1:0]  adp_data_s;
    logic              adp_req_valid_s, adp_rd_ready_s;

`ifdef SWA_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYCLES + 1);
    logic [TO_W-1:0]   to_cnt_r;
    logic              err_r;
    assign to_hit_s = !adp_rsp_valid && (to_cnt_r == TO_W'(TO_CYCLES - 1));
`else
    assign to_hit_s = 1'b0;
`endif

    // Round-robin search: first valid requester at or after the pointer, wrapping.
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_idx_s   = '0;
        cand_s      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_s = {1'b0, ptr_r} + (IW+1)'(i);
            cand_s = (cand_s >= (IW+1)'(NREQ)) ? cand_s - (IW+1)'(NREQ) : cand_s;
            if (!gnt_found_s && req_valid_i[cand_s[IW-1:0]]) begin
                gnt_found_s = 1'b1;
                gnt_idx_s   = cand_s[IW-1:0];
            end else begin
                gnt_found_s = gnt_found_s;
            end
        end
    end

    assign ptr_inc_s = {1'b0, gnt_r} + (IW+1)'(1);
    assign ptr_nxt_s = (ptr_inc_s >= (IW+1)'(NREQ)) ? '0 : ptr_inc_s[IW-1:0];

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_nxt_s     = state_r;
        req_ready_s     = '0;
        rsp_valid_s     = '0;
        adp_data_s      = '0;
        adp_req_valid_s = 1'b0;
        adp_rd_ready_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (gnt_found_s) begin
                    req_ready_s = NREQ'(1) << gnt_idx_s;
                    state_nxt_s = S_REQ;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_REQ: begin
                adp_req_valid_s = 1'b1;
                case (beat_r)
                    2'd0:    adp_data_s = '0;
                    2'd1:    adp_data_s = {{(PKT_S-DT_S){1'b0}}, type_r};
                    2'd2:    adp_data_s = key_r[KH_S-1:PKT_S];
                    2'd3:    adp_data_s = key_r[PKT_S-1:0];
                    default: adp_data_s = '0;
                endcase
                if (beat_r == 2'd3) begin
                    state_nxt_s = S_RSP;
                end else begin
                    state_nxt_s = S_REQ;
                end
            end
            S_RSP: begin
                adp_rd_ready_s = 1'b1;
                if (adp_rsp_valid && word_r == 2'd3) begin
                    state_nxt_s = S_DLV;
                end else if (to_hit_s) begin
                    state_nxt_s = S_DLV;
                end else begin
                    state_nxt_s = S_RSP;
                end
            end
            S_DLV: begin
                rsp_valid_s = NREQ'(1) << gnt_r;
                if (rsp_ready_i) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_DLV;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Datapath: request latch, beat/word counters, response capture, rr pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r  <= '0;
            gnt_r  <= '0;
            type_r <= '0;
            key_r  <= '0;
            beat_r <= 2'd0;
            word_r <= 2'd0;
            data_r <= '0;
`ifdef SWA_ARB_TIMEOUT_EN
            to_cnt_r <= '0;
            err_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (gnt_found_s) begin
                        gnt_r  <= gnt_idx_s;
                        type_r <= req_type_i[gnt_idx_s*DT_S +: DT_S];
                        key_r  <= req_key_i[gnt_idx_s*KH_S +: KH_S];
                        beat_r <= 2'd0;
                        word_r <= 2'd0;
                        data_r <= '0;
`ifdef SWA_ARB_TIMEOUT_EN
                        to_cnt_r <= '0;
                        err_r    <= 1'b0;
`endif
                    end
                end
                S_REQ: beat_r <= beat_r + 2'd1;
                S_RSP: begin
                    if (adp_rsp_valid) begin
                        data_r[word_r*PKT_S +: PKT_S] <= adp_data_out;
                        word_r <= word_r + 2'd1;
`ifdef SWA_ARB_TIMEOUT_EN
                        to_cnt_r <= '0;
                    end else if (to_hit_s) begin
                        // Partial words are discarded on timeout.
                        data_r <= '0;
                        err_r  <= 1'b1;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_W'(1);
`endif
                    end
                end
                S_DLV: begin
                    if (rsp_ready_i) begin
                        ptr_r <= ptr_nxt_s;
                    end
                end
                default: beat_r <= 2'd0;
            endcase
        end
    end

    // Outputs are forced low for the whole cycle in which rst is high.
    assign req_ready_o   = rst ? '0   : req_ready_s;
    assign rsp_valid_o   = rst ? '0   : rsp_valid_s;
    assign rsp_data_o    = rst ? '0   : data_r;
    assign adp_data_in   = rst ? '0   : adp_data_s;
    assign adp_req_valid = rst ? 1'b0 : adp_req_valid_s;
    assign adp_rd_ready  = rst ? 1'b0 : adp_rd_ready_s;
`ifdef SWA_ARB_TIMEOUT_EN
    assign rsp_err_o     = rst ? 1'b0 : err_r;
`else
    assign rsp_err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_sw_adaptor_arbiter.sv
// Directed self-checking bench for sw_adaptor_arbiter (NREQ=4, TO_CYCLES=8).
module tb_sw_adaptor_arbiter;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req_valid_i;
    logic [3:0]    req_ready_o;
    logic [11:0]   req_type_i;
    logic [255:0]  req_key_i;
    logic [3:0]    rsp_valid_o;
    logic          rsp_ready_i;
    logic [127:0]  rsp_data_o;
    logic          rsp_err_o;
    logic [31:0]   adp_data_in;
    logic          adp_req_valid;
    logic          adp_rd_ready;
    logic [31:0]   adp_data_out;
    logic          adp_rsp_valid;

    int n_cmp = 0;
    int n_bad = 0;
    logic [2:0]  tys  [4];
    logic [63:0] keys [4];

    sw_adaptor_arbiter #(.NREQ(4), .PKT_S(32), .D_S(128), .KH_S(64), .DT_S(3), .TO_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_type_i(req_type_i), .req_key_i(req_key_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .adp_data_in(adp_data_in), .adp_req_valid(adp_req_valid), .adp_rd_ready(adp_rd_ready),
        .adp_data_out(adp_data_out), .adp_rsp_valid(adp_rsp_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fields();
        req_type_i = {tys[3], tys[2], tys[1], tys[0]};
        req_key_i  = {keys[3], keys[2], keys[1], keys[0]};
    endtask

    // Full transaction for requester g, starting in IDLE with its request already driven.
    task automatic run_txn(input int g, input bit scr, input int gap, input int hold,
                           input logic [127:0] words);
        logic [31:0] exp_beat [4];
        exp_beat[0] = 32'h0;
        exp_beat[1] = {29'b0, tys[g]};
        exp_beat[2] = keys[g][63:32];
        exp_beat[3] = keys[g][31:0];
        #1;
        chk("grant", req_ready_o, 128'(4'b0001 << g));
        tick();
        if (scr) begin
            req_type_i[g*3 +: 3]  = ~tys[g];
            req_key_i[g*64 +: 64] = ~keys[g];
        end
        for (int b = 0; b < 4; b++) begin
            adp_rsp_valid = 1'b1;
            adp_data_out  = 32'hBAD0_BAD0;
            rsp_ready_i   = 1'b1;
            chk("req_valid", adp_req_valid, 1'b1);
            chk("req_beat", adp_data_in, exp_beat[b]);
            tick();
        end
        adp_rsp_valid = 1'b0;
        rsp_ready_i   = 1'b0;
        drive_fields();
        chk("rsp_phase", {adp_rd_ready, adp_req_valid, rsp_valid_o}, 6'b100000);
        for (int k = 0; k < 4; k++) begin
            adp_rsp_valid = 1'b1;
            adp_data_out  = words[k*32 +: 32];
            tick();
            adp_rsp_valid = 1'b0;
            adp_data_out  = 32'hDEAD_BEEF;
            if (k < 3) begin
                chk("early_rsp", rsp_valid_o, 4'b0000);
                repeat (gap) tick();
                if (gap > 0) chk("gap_rsp", {adp_rd_ready, rsp_valid_o}, 5'b10000);
            end
        end
        chk("rsp_valid", rsp_valid_o, 4'b0001 << g);
        chk("rsp_data", rsp_data_o, words);
        chk("rsp_err", rsp_err_o, 1'b0);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_valid", {req_ready_o, rsp_valid_o}, {4'b0000, 4'b0001 << g});
            chk("hold_data", rsp_data_o, words);
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
    endtask

    initial begin
        tys[0] = 3'd2;  keys[0] = 64'h0123_4567_89AB_CDEF;
        tys[1] = 3'd5;  keys[1] = 64'hA5A5_0000_1234_5678;
        tys[2] = 3'd7;  keys[2] = 64'hCAFE_F00D_0BAD_BEEF;
        tys[3] = 3'd4;  keys[3] = 64'h1357_9BDF_2468_ACE0;
        drive_fields();
        rst = 1'b1; req_valid_i = 4'hF; rsp_ready_i = 1'b0;
        adp_rsp_valid = 1'b1; adp_data_out = 32'hFFFF_FFFF;
        tick(); tick();
        chk("reset_outs", {|req_ready_o, |rsp_valid_o, |rsp_data_o, rsp_err_o,
                           |adp_data_in, adp_req_valid, adp_rd_ready}, 7'b0);
        rst = 1'b0; adp_rsp_valid = 1'b0; adp_data_out = '0;

        // Single request from requester 1, fields scrambled after the grant.
        req_valid_i = 4'b0010;
        run_txn(1, 1'b1, 0, 0, 128'h44444444_33333333_22222222_11111111);

        // Abort at REQ beat 2.
        req_valid_i = 4'b0100;
        #1;
        chk("abort_grant", req_ready_o, 4'b0100);
        tick(); tick(); tick();
        chk("abort_beat2", adp_data_in, keys[2][63:32]);
        rst = 1'b1;
        #1;
        chk("abort_outs", {|req_ready_o, |rsp_valid_o, |rsp_data_o, rsp_err_o,
                           |adp_data_in, adp_req_valid, adp_rd_ready}, 7'b0);
        tick();
        rst = 1'b0;
        req_valid_i = 4'hF;
        chk("abort_idle", {adp_req_valid, adp_rd_ready, rsp_valid_o}, 6'b0);

        // All requesters valid: pointer back at 0, grants rotate 0,1,2,3,0.
        run_txn(0, 1'b0, 2, 0, 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3);
        run_txn(1, 1'b0, 0, 5, 128'h01010101_02020202_03030303_04040404);
        run_txn(2, 1'b0, 0, 0, 128'hFEDCBA98_76543210_0F0F0F0F_F0F0F0F0);
        run_txn(3, 1'b0, 1, 0, 128'h12345678_9ABCDEF0_13579BDF_2468ACE0);
        run_txn(0, 1'b0, 0, 1, 128'h55555555_AAAAAAAA_5A5A5A5A_A5A5A5A5);

`ifdef SWA_ARB_TIMEOUT_EN
        // Silent adaptor: timeout after 8 idle RSP cycles.
        #1;
        chk("to_grant", req_ready_o, 4'b0010);
        repeat (5) tick();
        repeat (7) tick();
        chk("to_wait", {adp_rd_ready, rsp_valid_o}, 5'b10000);
        tick();
        chk("to_valid", rsp_valid_o, 4'b0010);
        chk("to_err", rsp_err_o, 1'b1);
        chk("to_data", rsp_data_o, 128'h0);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
